sd_rsp_receiver: RTL and testbench

Host-side SD CMD-line response receiver: samples the card's response bit-serially, checks framing, CRC7 and index, and optionally waits for DAT0 busy release. It is the receiving counterpart of the card response transmitter (R1/R1b/R3/R6/R7 48-bit, R2 136-bit). It sits in the SDHCI command path between the SD pad interface and the command/response register logic.

---
 rtl/sd_rsp_pkg.sv | 24 ++
 rtl/sd_crc7.sv | 28 ++
 rtl/sd_rsp_receiver.sv | 205 ++++++++++++++++++++
 tb/tb_sd_rsp_receiver.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_rsp_pkg.sv
// Shared constants, state encoding and CRC7 step function for the SD CMD-line
// response path (receiver and command transmitter).
package sd_rsp_pkg;

    localparam logic [6:0] Crc7Poly    = 7'h09;
    localparam int         RspShortLen = 48;
    localparam int         RspLongLen  = 136;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_RECEIVE,
        ST_WAIT_BUSY,
        ST_DONE
    } state_t;

    // One serial CRC7 step: shift left, fold the feedback bit into the taps.
    function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? Crc7Poly : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator. clr_i with en_i seeds zero and clocks the bit in the
// same cycle, so a frame's first bit needs no separate clear cycle.
module sd_crc7
    import sd_rsp_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_reg <= 7'h00;
        end else if (clr_i) begin
            crc_reg <= en_i ? crc7_next(7'h00, bit_i) : 7'h00;
        end else if (en_i) begin
            crc_reg <= crc7_next(crc_reg, bit_i);
        end
    end

    assign crc_o = crc_reg;

endmodule

// File: rtl/sd_rsp_receiver.sv
// Host-side SD CMD response receiver: start-bit search, framing/CRC7/index
// checks for 48- and 136-bit responses, optional DAT0 busy wait.
module sd_rsp_receiver
    import sd_rsp_pkg::*;
#(
    parameter int NcrTimeout  = 64,
    parameter int BusyTimeout = 0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         sample_i,
    input  logic         sd_cmd_i,
    input  logic         sd_dat0_i,
    input  logic         start_i,
    input  logic         rsp_long_i,
    input  logic         check_busy_i,
    input  logic         index_check_en_i,
    input  logic         crc_check_en_i,
    input  logic [5:0]   expected_index_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [119:0] rsp_o,
    output logic         timeout_err_o,
    output logic         crc_err_o,
    output logic         end_bit_err_o,
    output logic         index_err_o
);

    localparam int NcrW  = $clog2(NcrTimeout) + 1;
    localparam int BusyW = $clog2(BusyTimeout) + 1;
    localparam logic [NcrW-1:0]  NcrLast  = NcrW'(NcrTimeout - 1);
    localparam logic [BusyW-1:0] BusyLast = BusyW'(BusyTimeout - 1);

    state_t             state_reg;
    logic [7:0]         bit_cnt_reg;
    logic [NcrW-1:0]    ncr_cnt_reg;
    logic [BusyW-1:0]   busy_cnt_reg;
    logic               long_reg, check_busy_reg, idx_en_reg, crc_en_reg;
    logic [5:0]         exp_idx_reg, idx_rx_reg;
    logic [6:0]         crc_rx_reg;
    logic               tx_err_reg;
    logic [119:0]       rsp_reg;
    logic               done_reg, busy_reg;
    logic               timeout_err_reg, crc_err_reg, end_err_reg, idx_err_reg;

    logic [7:0] last_idx, crc_lo;
    logic       crc_clr, crc_en;
    logic [6:0] crc_calc;

    assign last_idx = long_reg ? 8'(RspLongLen - 1) : 8'(RspShortLen - 1);
    assign crc_lo   = last_idx - 8'd7;

    // Long frames restart the CRC at bit 8; short frames run it from the start bit.
    always_comb begin
        crc_clr = 1'b0;
        crc_en  = 1'b0;
        if (sample_i) begin
            case (state_reg)
                ST_WAIT_START: begin
                    crc_clr = !sd_cmd_i;
                    crc_en  = !sd_cmd_i;
                end
                ST_RECEIVE: begin
                    crc_en  = (bit_cnt_reg < crc_lo) && (!long_reg || bit_cnt_reg >= 8'd8);
                    crc_clr = long_reg && (bit_cnt_reg == 8'd8);
                end
                default: ;
            endcase
        end
    end

    sd_crc7 u_crc7 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (crc_clr),
        .en_i  (crc_en),
        .bit_i (sd_cmd_i),
        .crc_o (crc_calc)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg       <= ST_IDLE;
            bit_cnt_reg     <= '0;
            ncr_cnt_reg     <= '0;
            busy_cnt_reg    <= '0;
            long_reg        <= 1'b0;
            check_busy_reg  <= 1'b0;
            idx_en_reg      <= 1'b0;
            crc_en_reg      <= 1'b0;
            exp_idx_reg     <= '0;
            idx_rx_reg      <= '0;
            crc_rx_reg      <= '0;
            tx_err_reg      <= 1'b0;
            rsp_reg         <= '0;
            done_reg        <= 1'b0;
            busy_reg        <= 1'b0;
            timeout_err_reg <= 1'b0;
            crc_err_reg     <= 1'b0;
            end_err_reg     <= 1'b0;
            idx_err_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start_i) begin
                        long_reg        <= rsp_long_i;
                        check_busy_reg  <= check_busy_i;
                        idx_en_reg      <= index_check_en_i && !rsp_long_i;
                        crc_en_reg      <= crc_check_en_i;
                        exp_idx_reg     <= expected_index_i;
                        bit_cnt_reg     <= '0;
                        ncr_cnt_reg     <= '0;
                        busy_cnt_reg    <= '0;
                        idx_rx_reg      <= '0;
                        crc_rx_reg      <= '0;
                        tx_err_reg      <= 1'b0;
                        rsp_reg         <= '0;
                        timeout_err_reg <= 1'b0;
                        crc_err_reg     <= 1'b0;
                        end_err_reg     <= 1'b0;
                        idx_err_reg     <= 1'b0;
                        busy_reg        <= 1'b1;
                        state_reg       <= ST_WAIT_START;
                    end
                end
                ST_WAIT_START: begin
                    if (sample_i) begin
                        if (!sd_cmd_i) begin
                            bit_cnt_reg <= 8'd1;
                            state_reg   <= ST_RECEIVE;
                        end else if (ncr_cnt_reg >= NcrLast) begin
                            timeout_err_reg <= 1'b1;
                            done_reg        <= 1'b1;
                            busy_reg        <= 1'b0;
                            state_reg       <= ST_DONE;
                        end else begin
                            ncr_cnt_reg <= ncr_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_RECEIVE: begin
                    if (sample_i) begin
                        if (bit_cnt_reg == 8'd1 && sd_cmd_i)
                            tx_err_reg <= 1'b1;
                        if (!long_reg && bit_cnt_reg >= 8'd2 && bit_cnt_reg < 8'd8)
                            idx_rx_reg <= {idx_rx_reg[4:0], sd_cmd_i};
                        if (bit_cnt_reg >= 8'd8 && bit_cnt_reg < crc_lo) begin
                            if (long_reg)
                                rsp_reg <= {rsp_reg[118:0], sd_cmd_i};
                            else
                                rsp_reg[31:0] <= {rsp_reg[30:0], sd_cmd_i};
                        end
                        if (bit_cnt_reg >= crc_lo && bit_cnt_reg < last_idx)
                            crc_rx_reg <= {crc_rx_reg[5:0], sd_cmd_i};

                        if (bit_cnt_reg == last_idx) begin
                            crc_err_reg <= crc_en_reg && (crc_rx_reg != crc_calc);
                            idx_err_reg <= idx_en_reg && (idx_rx_reg != exp_idx_reg);
                            end_err_reg <= tx_err_reg || !sd_cmd_i;
                            if (check_busy_reg) begin
                                state_reg <= ST_WAIT_BUSY;
                            end else begin
                                done_reg  <= 1'b1;
                                busy_reg  <= 1'b0;
                                state_reg <= ST_DONE;
                            end
                        end else if (bit_cnt_reg != 8'hFF) begin
                            bit_cnt_reg <= bit_cnt_reg + 8'd1;
                        end
                    end
                end
                ST_WAIT_BUSY: begin
                    if (sample_i) begin
                        if (sd_dat0_i) begin
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= ST_DONE;
                        end else if (BusyTimeout != 0 && busy_cnt_reg >= BusyLast) begin
                            timeout_err_reg <= 1'b1;
                            done_reg        <= 1'b1;
                            busy_reg        <= 1'b0;
                            state_reg       <= ST_DONE;
                        end else if (busy_cnt_reg != '1) begin
                            busy_cnt_reg <= busy_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy_o        = busy_reg;
    assign done_o        = done_reg;
    assign rsp_o         = rsp_reg;
    assign timeout_err_o = timeout_err_reg;
    assign crc_err_o     = crc_err_reg;
    assign end_bit_err_o = end_err_reg;
    assign index_err_o   = idx_err_reg;

endmodule

// File: tb/tb_sd_rsp_receiver.sv
// Bench for sd_rsp_receiver: two instances (no busy timeout / BusyTimeout=4)
// driven in lockstep, checked against a polynomial-division CRC7 frame model.
module tb_sd_rsp_receiver;

    logic         clk = 1'b0;
    logic         rst, sample, cmd, dat0, start, rsp_long, check_busy, idx_en, crc_en;
    logic [5:0]   exp_idx;
    logic         busy, done, to_err, crc_err, end_err, idx_err;
    logic [119:0] rsp;
    logic         busy_b, done_b, to_err_b, crc_err_b, end_err_b, idx_err_b;
    logic [119:0] rsp_b;

    int n_cmp = 0;
    int n_fail = 0;
    int done_cnt = 0;
    logic last_done, last_done_b, early_done;

    always #5 clk = ~clk;
    always @(posedge clk) done_cnt <= done_cnt + int'(done);

    sd_rsp_receiver #(.NcrTimeout(64), .BusyTimeout(0)) dut (
        .clk_i(clk), .rst_i(rst), .sample_i(sample), .sd_cmd_i(cmd), .sd_dat0_i(dat0),
        .start_i(start), .rsp_long_i(rsp_long), .check_busy_i(check_busy),
        .index_check_en_i(idx_en), .crc_check_en_i(crc_en), .expected_index_i(exp_idx),
        .busy_o(busy), .done_o(done), .rsp_o(rsp), .timeout_err_o(to_err),
        .crc_err_o(crc_err), .end_bit_err_o(end_err), .index_err_o(idx_err));

    sd_rsp_receiver #(.NcrTimeout(64), .BusyTimeout(4)) dut_bt (
        .clk_i(clk), .rst_i(rst), .sample_i(sample), .sd_cmd_i(cmd), .sd_dat0_i(dat0),
        .start_i(start), .rsp_long_i(rsp_long), .check_busy_i(check_busy),
        .index_check_en_i(idx_en), .crc_check_en_i(crc_en), .expected_index_i(exp_idx),
        .busy_o(busy_b), .done_o(done_b), .rsp_o(rsp_b), .timeout_err_o(to_err_b),
        .crc_err_o(crc_err_b), .end_bit_err_o(end_err_b), .index_err_o(idx_err_b));

    // Reference CRC7: remainder of msg(x)*x^7 divided by x^7+x^3+1 (long division).
    function automatic logic [6:0] crc7_ref(input logic [119:0] msg, input int n);
        logic [127:0] r;
        r = {8'h00, msg} << 7;
        for (int i = n + 6; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // A strobe rides along with start_i; it must not be taken as a start bit.
    task automatic arm(input logic lng, input logic bsy, input logic ien,
                       input logic cen, input logic [5:0] ei);
        start = 1'b1; rsp_long = lng; check_busy = bsy; idx_en = ien; crc_en = cen;
        exp_idx = ei; sample = 1'b1; cmd = 1'b0;
        @(negedge clk);
        start = 1'b0; sample = 1'b0; cmd = 1'b1;
        @(negedge clk);
    endtask

    task automatic strobe(input logic c, input logic d);
        cmd = c; dat0 = d; sample = 1'b1;
        @(negedge clk);
        sample = 1'b0;
        last_done = done;
        last_done_b = done_b;
        @(negedge clk);
    endtask

    task automatic send_bits(input logic [135:0] f, input int len, input int from, input int upto);
        early_done = 1'b0;
        for (int i = from; i < upto; i++) begin
            strobe(f[len-1-i], 1'b1);
            if (i != upto - 1 && last_done) early_done = 1'b1;
        end
    endtask

    task automatic test_reset();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
        n_cmp++; if (rsp !== 120'h0) begin n_fail++; $display("FAIL reset_rsp got=%h want=0", rsp); end
        n_cmp++; if ({to_err, crc_err, end_err, idx_err} !== 4'b0000)
            begin n_fail++; $display("FAIL reset_errs got=%b want=0000", {to_err, crc_err, end_err, idx_err}); end
        $display("reset: busy=%b done=%b errs=%b", busy, done, {to_err, crc_err, end_err, idx_err});
    endtask

    typedef struct {
        logic [47:0] f;
        logic        ien, cen;
        logic [5:0]  ei;
        logic        ec, ex, ee;
        logic [31:0] er;
    } r7_case_t;

    task automatic test_r7_cases();
        r7_case_t tc[6];
        tc[0] = '{48'h08_000001AA_13, 1, 1, 6'd8,  0, 0, 0, 32'h000001AA};
        tc[1] = '{48'h08_000001AA_15, 1, 1, 6'd8,  1, 0, 0, 32'h000001AA};
        tc[2] = '{48'h08_000001AA_15, 1, 0, 6'd8,  0, 0, 0, 32'h000001AA};
        tc[3] = '{48'h08_000001AA_13, 1, 1, 6'd17, 0, 1, 0, 32'h000001AA};
        tc[4] = '{48'h08_000001AA_12, 1, 1, 6'd8,  0, 0, 1, 32'h000001AA};
        tc[5] = '{48'h40_00000000_95, 0, 1, 6'd0,  0, 0, 1, 32'h00000000};
        for (int k = 0; k < 6; k++) begin
            arm(1'b0, 1'b0, tc[k].ien, tc[k].cen, tc[k].ei);
            n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL r7_busy[%0d] got=%b want=1", k, busy); end
            repeat ($urandom_range(0, 3)) strobe(1'b1, 1'b1);
            send_bits({88'h0, tc[k].f}, 48, 0, 48);
            n_cmp++; if ({early_done, last_done} !== 2'b01)
                begin n_fail++; $display("FAIL r7_done[%0d] got=%b want=01", k, {early_done, last_done}); end
            n_cmp++; if (rsp !== {88'h0, tc[k].er}) begin n_fail++; $display("FAIL r7_rsp[%0d] got=%h want=%h", k, rsp, tc[k].er); end
            n_cmp++; if ({to_err, crc_err, idx_err, end_err} !== {1'b0, tc[k].ec, tc[k].ex, tc[k].ee})
                begin n_fail++; $display("FAIL r7_errs[%0d] got=%b want=%b", k, {to_err, crc_err, idx_err, end_err}, {1'b0, tc[k].ec, tc[k].ex, tc[k].ee}); end
            $display("r7[%0d]: frame=%h rsp=%h t/c/i/e=%b", k, tc[k].f, rsp[31:0], {to_err, crc_err, idx_err, end_err});
        end
    endtask

    task automatic test_random_short();
        for (int k = 0; k < 16; k++) begin
            logic [5:0]  idx, ei;
            logic [31:0] arg;
            logic        crc_bad, tx1, end0, ien, cen;
            logic [6:0]  crc;
            logic [47:0] f;
            idx = 6'($urandom); arg = $urandom;
            ei = ($urandom_range(0, 1) == 1) ? idx : 6'($urandom);
            crc_bad = ($urandom_range(0, 2) == 0); tx1 = ($urandom_range(0, 3) == 0);
            end0 = ($urandom_range(0, 3) == 0);
            ien = 1'($urandom); cen = 1'($urandom);
            crc = crc7_ref({80'h0, 1'b0, tx1, idx, arg}, 40);
            if (crc_bad) crc = crc ^ 7'(1 << $urandom_range(0, 6));
            f = {1'b0, tx1, idx, arg, crc, !end0};
            arm(1'b0, 1'b0, ien, cen, ei);
            repeat ($urandom_range(0, 5)) strobe(1'b1, 1'b1);
            send_bits({88'h0, f}, 48, 0, 48);
            n_cmp++; if ({early_done, last_done} !== 2'b01)
                begin n_fail++; $display("FAIL rnd_done[%0d] got=%b want=01", k, {early_done, last_done}); end
            n_cmp++; if (rsp !== {88'h0, arg}) begin n_fail++; $display("FAIL rnd_rsp[%0d] got=%h want=%h", k, rsp, arg); end
            n_cmp++; if ({to_err, crc_err, idx_err, end_err} !== {1'b0, cen && crc_bad, ien && (idx != ei), tx1 || end0})
                begin n_fail++; $display("FAIL rnd_errs[%0d] got=%b want=%b", k, {to_err, crc_err, idx_err, end_err},
                                         {1'b0, cen && crc_bad, ien && (idx != ei), tx1 || end0}); end
            $display("rnd[%0d]: frame=%h rsp=%h t/c/i/e=%b", k, f, rsp[31:0], {to_err, crc_err, idx_err, end_err});
        end
    endtask

    task automatic test_timeout();
        logic any_early = 1'b0;
        arm(1'b0, 1'b0, 1'b1, 1'b1, 6'd8);
        for (int k = 1; k <= 64; k++) begin
            strobe(1'b1, 1'b1);
            if (k < 64 && (last_done || last_done_b)) any_early = 1'b1;
        end
        n_cmp++; if (any_early !== 1'b0) begin n_fail++; $display("FAIL to_early got=%b want=0", any_early); end
        n_cmp++; if ({last_done, last_done_b} !== 2'b11) begin n_fail++; $display("FAIL to_done got=%b want=11", {last_done, last_done_b}); end
        n_cmp++; if ({to_err, to_err_b, busy} !== 3'b110) begin n_fail++; $display("FAIL to_flags got=%b want=110", {to_err, to_err_b, busy}); end
        $display("timeout: done=%b to_err=%b busy=%b", last_done, to_err, busy);
    endtask

    task automatic test_busy();
        logic bad_b = 1'b0;
        logic bad = 1'b0;
        arm(1'b0, 1'b1, 1'b1, 1'b1, 6'd8);
        send_bits({88'h0, 48'h08_000001AA_13}, 48, 0, 48);
        n_cmp++; if ({last_done, last_done_b} !== 2'b00) begin n_fail++; $display("FAIL busy_end_done got=%b want=00", {last_done, last_done_b}); end
        for (int k = 1; k <= 10; k++) begin
            strobe(1'b1, 1'b0);
            if (last_done) bad = 1'b1;
            if (last_done_b !== (k == 4)) bad_b = 1'b1;
        end
        n_cmp++; if (bad !== 1'b0) begin n_fail++; $display("FAIL busy_low_done got=%b want=0", bad); end
        n_cmp++; if ({bad_b, to_err_b} !== 2'b01) begin n_fail++; $display("FAIL busy_bt got=%b want=01", {bad_b, to_err_b}); end
        strobe(1'b1, 1'b1);
        n_cmp++; if ({last_done, to_err, crc_err, idx_err, end_err} !== 5'b10000)
            begin n_fail++; $display("FAIL busy_release got=%b want=10000", {last_done, to_err, crc_err, idx_err, end_err}); end
        dat0 = 1'b1;
        $display("r1b: done=%b to_err=%b bt_to_err=%b", last_done, to_err, to_err_b);
    endtask

    task automatic test_r2();
        for (int k = 0; k < 3; k++) begin
            logic [119:0] pl;
            logic [6:0]   crc;
            logic         bad;
            pl = {$urandom, $urandom, $urandom, 24'($urandom)};
            bad = (k == 2);
            crc = crc7_ref(pl, 120) ^ (bad ? 7'h40 : 7'h00);
            arm(1'b1, 1'b0, 1'b1, 1'b1, 6'd0);
            send_bits({2'b00, 6'h3F, pl, crc, 1'b1}, 136, 0, 136);
            n_cmp++; if ({early_done, last_done} !== 2'b01)
                begin n_fail++; $display("FAIL r2_done[%0d] got=%b want=01", k, {early_done, last_done}); end
            n_cmp++; if (rsp !== pl) begin n_fail++; $display("FAIL r2_rsp[%0d] got=%h want=%h", k, rsp, pl); end
            n_cmp++; if ({to_err, crc_err, idx_err, end_err} !== {1'b0, bad, 2'b00})
                begin n_fail++; $display("FAIL r2_errs[%0d] got=%b want=%b", k, {to_err, crc_err, idx_err, end_err}, {1'b0, bad, 2'b00}); end
            $display("r2[%0d]: rsp=%h crc_err=%b", k, rsp, crc_err);
        end
    endtask

    task automatic test_reset_mid();
        logic [47:0] f;
        int          cnt0;
        f = {2'b00, 6'd3, 32'hFFFF_FFFF, crc7_ref({80'h0, 2'b00, 6'd3, 32'hFFFF_FFFF}, 40), 1'b1};
        arm(1'b0, 1'b0, 1'b1, 1'b1, 6'd3);
        send_bits({88'h0, f}, 48, 0, 20);
        do_reset();
        n_cmp++; if ({busy, done, to_err, crc_err, end_err, idx_err} !== 6'b0 || rsp !== 120'h0)
            begin n_fail++; $display("FAIL rstmid_outs got=%b/%h want=0/0", {busy, done, to_err, crc_err, end_err, idx_err}, rsp); end
        cnt0 = done_cnt;
        send_bits({88'h0, f}, 48, 20, 48);
        n_cmp++; if (done_cnt !== cnt0) begin n_fail++; $display("FAIL rstmid_done got=%0d want=%0d", done_cnt, cnt0); end
        $display("rst_mid: busy=%b rsp=%h done_pulses=%0d", busy, rsp, done_cnt - cnt0);
    endtask

    task automatic test_start_ignored();
        arm(1'b0, 1'b0, 1'b1, 1'b1, 6'd8);
        send_bits({88'h0, 48'h08_000001AA_13}, 48, 0, 10);
        start = 1'b1; rsp_long = 1'b1; check_busy = 1'b1; exp_idx = 6'd17;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ign_busy got=%b want=1", busy); end
        send_bits({88'h0, 48'h08_000001AA_13}, 48, 10, 48);
        n_cmp++; if ({early_done, last_done} !== 2'b01)
            begin n_fail++; $display("FAIL ign_done got=%b want=01", {early_done, last_done}); end
        n_cmp++; if (rsp !== 120'h1AA || {to_err, crc_err, idx_err, end_err} !== 4'b0000)
            begin n_fail++; $display("FAIL ign_result got=%h/%b want=1aa/0000", rsp, {to_err, crc_err, idx_err, end_err}); end
        $display("start_ignored: rsp=%h errs=%b", rsp[31:0], {to_err, crc_err, idx_err, end_err});
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sample = 1'b0; cmd = 1'b1; dat0 = 1'b1; start = 1'b0;
        rsp_long = 1'b0; check_busy = 1'b0; idx_en = 1'b0; crc_en = 1'b0; exp_idx = '0;
        last_done = 1'b0; last_done_b = 1'b0; early_done = 1'b0;
        @(negedge clk);
        do_reset();
        test_reset();
        test_r7_cases();
        test_random_short();
        test_timeout();
        test_busy();
        test_r2();
        test_reset_mid();
        test_start_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
